// File: rtl/inv_round_front.sv
// Front half of an AES inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey, valid/ready with a skid.
// Define INV_ROUND_PIPE_SBOX_EN to add a mid register after InvSubBytes (latency 2).
module inv_round_front #(
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_state,
    input  logic [127:0]       in_key,
    input  logic [ROUND_W-1:0] in_round,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_state,
    output logic [ROUND_W-1:0] out_round,
    output logic               out_last
);
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
        endcase
        return s;
    endfunction

    // Byte (col c, row r) lives at bits [c*32+31-8r -: 8]
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[c*32+31-8*r -: 8] = s[((c-r+4)%4)*32+31-8*r -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[i*8 +: 8] = inv_sbox(s[i*8 +: 8]);
        return o;
    endfunction

    logic               skid_valid;
    logic [127:0]       skid_state, skid_key;
    logic [ROUND_W-1:0] skid_round;
    logic               skid_last;
    logic               adv, accept, load;
    logic [127:0]       src_state, src_key, sub_state;
    logic [ROUND_W-1:0] src_round;
    logic               src_last;

    assign in_ready  = !skid_valid && !rst;
    assign adv       = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign load      = adv && (skid_valid || accept);
    assign src_state = skid_valid ? skid_state : in_state;
    assign src_key   = skid_valid ? skid_key   : in_key;
    assign src_round = skid_valid ? skid_round : in_round;
    assign src_last  = skid_valid ? skid_last  : in_last;
    assign sub_state = inv_sub_bytes(inv_shift_rows(src_state));

    // Skid holds raw inputs only; it is computed when it drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_state <= '0;
            skid_key   <= '0;
            skid_round <= '0;
            skid_last  <= 1'b0;
        end else if (adv) begin
            skid_valid <= 1'b0;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_state <= in_state;
            skid_key   <= in_key;
            skid_round <= in_round;
            skid_last  <= in_last;
        end
    end

`ifdef INV_ROUND_PIPE_SBOX_EN
    logic               mid_valid;
    logic [127:0]       mid_sub, mid_key;
    logic [ROUND_W-1:0] mid_round;
    logic               mid_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mid_valid <= 1'b0;
            mid_sub   <= '0;
            mid_key   <= '0;
            mid_round <= '0;
            mid_last  <= 1'b0;
            out_valid <= 1'b0;
            out_state <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            mid_valid <= load;
            if (load) begin
                mid_sub   <= sub_state;
                mid_key   <= src_key;
                mid_round <= src_round;
                mid_last  <= src_last;
            end
            out_valid <= mid_valid;
            if (mid_valid) begin
                out_state <= mid_sub ^ mid_key;
                out_round <= mid_round;
                out_last  <= mid_last;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_state <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= load;
            if (load) begin
                out_state <= sub_state ^ src_key;
                out_round <= src_round;
                out_last  <= src_last;
            end
        end
    end
`endif
endmodule

// File: tb/tb_inv_round_front.sv
// Scoreboard bench for inv_round_front; expected values come from an S-box derived in GF(2^8).
module tb_inv_round_front;
    localparam int RW = 4;
    localparam int EW = 129 + RW;
`ifdef INV_ROUND_PIPE_SBOX_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [127:0]  in_state = '0, in_key = '0;
    logic [RW-1:0] in_round = '0;
    logic          out_valid, out_ready = 1'b1, out_last;
    logic [127:0]  out_state;
    logic [RW-1:0] out_round;

    inv_round_front #(.ROUND_W(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_key(in_key),
        .in_round(in_round), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_out = 0;
    logic [7:0]    isb [256];
    logic [EW-1:0] q [$];

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic int lsb(input int c, input int r);
        return c * 32 + 24 - 8 * r;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[lsb(c, r) +: 8] = isb[st[lsb((c + 4 - r) % 4, r) +: 8]] ^ key[lsb(c, r) +: 8];
        return o;
    endfunction

    // Output side: every valid beat must match the scoreboard head; pop on handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out", 160'(out_valid), 160'(0));
                else begin
                    chk("out_beat", 160'({out_last, out_round, out_state}), 160'(q[0]));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back({in_last, in_round, model(in_state, in_key)});
        end
    end

    task automatic send(input logic [127:0] st, input logic [127:0] key,
                        input logic [RW-1:0] rnd, input logic lst);
        in_valid = 1'b1; in_state = st; in_key = key; in_round = rnd; in_last = lst;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t == 49) chk("send_timeout", 160'(in_ready), 160'(1));
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 160'(q.size()), 160'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] inv, s;
        logic [127:0] e;
        logic [127:0] st6 [6], ky6 [6];
        int n, base;
        logic acc;

        // Inverse S-box built from the forward affine map over GF(2^8) inverses
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            isb[s] = 8'(x);
        end

        #1;
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_in_ready", 160'(in_ready), 160'(0));
        chk("rst_out_state", 160'(out_state), 160'(0));
        chk("rst_side", 160'({out_round, out_last}), 160'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rel_in_ready", 160'(in_ready), 160'(1));

        // Test 1: zero state and key, checked at the exact latency
        @(posedge clk); #1;
        send('0, '0, 4'd9, 1'b0);
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("t1_valid", 160'(out_valid), 160'(1));
        chk("t1_state", 160'(out_state), 160'({16{8'h52}}));
        chk("t1_round", 160'(out_round), 160'(9));
        drain();

        // Test 2: one 0x63 byte at col0,row1 moves to col1,row1
        e = {16{8'h52}}; e[23:16] = 8'h63;
        send(e, '0, 4'd3, 1'b0);
        repeat (LAT - 1) @(posedge clk);
        #1;
        e = {16{8'h48}}; e[55:48] = 8'h00;
        chk("t2_state", 160'(out_state), 160'(e));
        drain();

        // Test 3: key cancels S-box output; last flag passes through
        send('0, {16{8'h52}}, 4'd10, 1'b1);
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("t3_state", 160'(out_state), 160'(0));
        chk("t3_last", 160'(out_last), 160'(1));
        drain();

        // Test 4: 6-beat stream with out_ready low for cycles 2-4
        for (int i = 0; i < 6; i++) begin
            st6[i] = {$urandom, $urandom, $urandom, $urandom};
            ky6[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        n = 0; base = n_out;
        for (int cyc = 0; cyc < 40 && (n < 6 || q.size() != 0); cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid = (n < 6);
            in_state = st6[n % 6]; in_key = ky6[n % 6];
            in_round = RW'(n); in_last = 1'b0;
            @(negedge clk);
            if (cyc >= 1 && cyc <= 5) chk("stall_in_ready", 160'(in_ready), 160'(cyc < 3));
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) n++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("t4_accepted", 160'(n), 160'(6));
        chk("t4_emitted", 160'(n_out - base), 160'(6));

        // Sustained stream: out_valid must be high for exactly 8 consecutive cycles
        for (int i = 0; i < 8 + LAT + 1; i++) begin
            in_valid = (i < 8);
            in_state = {$urandom, $urandom, $urandom, $urandom};
            in_key = {$urandom, $urandom, $urandom, $urandom};
            in_round = RW'(i); in_last = i[0];
            @(negedge clk);
            if (i < 8) chk("tput_in_ready", 160'(in_ready), 160'(1));
            chk("tput_out_valid", 160'(out_valid), 160'(i >= LAT && i < 8 + LAT));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Random traffic with random backpressure
        n = 0;
        for (int cyc = 0; cyc < 400 && n < 30; cyc++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_state = {$urandom, $urandom, $urandom, $urandom};
                in_key = {$urandom, $urandom, $urandom, $urandom};
                in_round = RW'($urandom); in_last = 1'($urandom);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin n++; in_valid = 1'b0; end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("rand_accepted", 160'(n), 160'(30));
        drain();

        // Test 5: reset with output and skid both full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_state = {4{32'h1234_5678}}; in_key = {4{32'h9abc_def0}}; in_round = 4'd7;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (!in_ready) break;
            @(posedge clk); #1;
        end
        chk("pre_rst_out_valid", 160'(out_valid), 160'(1));
        chk("pre_rst_skid_full", 160'(in_ready), 160'(0));
        #2 rst = 1'b1;
        in_valid = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_out_valid", 160'(out_valid), 160'(0));
        chk("mid_rst_in_ready", 160'(in_ready), 160'(0));
        chk("mid_rst_out_state", 160'(out_state), 160'(0));
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        #1 chk("post_rst_in_ready", 160'(in_ready), 160'(1));
        repeat (5) @(posedge clk);
        #1 chk("post_rst_no_stale", 160'(out_valid), 160'(0));

        send(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h5a5a, 4'd1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
